// File: rtl/led_arb_pkg.sv
// Shared constants for the LED blink arbiter: FSM state encoding and blink-count width.
package led_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam int CNT_W = 4;

endpackage

// File: rtl/led_blink_arbiter_if.sv
// Request/grant bundle between the status sources (master) and the LED arbiter (slave).
interface led_blink_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import led_arb_pkg::*;

  logic [NUM_REQ-1:0]       req;
  logic [CNT_W*NUM_REQ-1:0] req_count;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;

  modport master (output req, req_count, input gnt, done, busy);
  modport slave  (input req, req_count, output gnt, done, busy);

endinterface

// File: rtl/led_tick_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module led_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: cnt_d gets a value on every path (default first), so no latch is inferred.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter sharing one LED: each winner gets a burst of blinks followed by a dark gap.
module led_blink_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HALF_PERIOD = 50_000_000,
  parameter int GAP_HALVES  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  led_blink_arbiter_if.slave  bus,
  output logic                led
);
  import led_arb_pkg::*;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = IW + 1;
  localparam int TW = $clog2(HALF_PERIOD * GAP_HALVES + 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_PERIOD - 1);
  // The gap runs one cycle longer than GAP_HALVES half-periods; that cycle closes the burst.
  localparam logic [TW-1:0] GAP_LOAD  = TW'(HALF_PERIOD * GAP_HALVES);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [IW-1:0]      win_q, win_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic               led_q, led_d;

  logic               tmr_load, tmr_expire;
  logic [TW-1:0]      tmr_val;

  logic               found;
  logic [IW-1:0]      pick;
  logic [CNT_W-1:0]   pick_count;
  logic [SW-1:0]      scan_sum;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] w);
    return (w == IW'(NUM_REQ - 1)) ? '0 : w + 1'b1;
  endfunction

  // First requester at or above rr_q, wrapping around.
  always_comb begin
    found      = 1'b0;
    pick       = '0;
    scan_sum   = '0;
    pick_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_q} + SW'(i);
      if (scan_sum >= SW'(NUM_REQ)) scan_sum = scan_sum - SW'(NUM_REQ);
      if (!found && bus.req[scan_sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = scan_sum[IW-1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IW'(i)) pick_count = bus.req_count[i*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    win_d    = win_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          win_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          rem_d       = pick_count;
          tmr_load    = 1'b1;
          if (pick_count == '0) begin
            state_d = ST_GAP;
            tmr_val = GAP_LOAD;
          end else begin
            state_d = ST_ON;
            tmr_val = HALF_LOAD;
          end
        end
      end
      default: begin
        if (!bus.req[win_q]) begin
          // Abort: release at once, no done pulse and no enforced gap.
          state_d  = ST_IDLE;
          gnt_d    = '0;
          rr_d     = next_idx(win_q);
          tmr_load = 1'b1;
        end else if (tmr_expire) begin
          tmr_load = 1'b1;
          case (state_q)
            ST_ON: begin
              state_d = ST_OFF;
              tmr_val = HALF_LOAD;
            end
            ST_OFF: begin
              rem_d = rem_q - 1'b1;
              if (rem_q == CNT_W'(1)) begin
                state_d = ST_GAP;
                tmr_val = GAP_LOAD;
              end else begin
                state_d = ST_ON;
                tmr_val = HALF_LOAD;
              end
            end
            default: begin
              state_d = ST_IDLE;
              done_d  = gnt_q;
              gnt_d   = '0;
              rr_d    = next_idx(win_q);
            end
          endcase
        end
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    led_d  = (state_d == ST_ON);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      win_q   <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  led_tick_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign led      = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requests against a cycle-offset burst model.
module tb_led_blink_arbiter;

  localparam int NR = 4;
  localparam int HP = 4;
  localparam int GH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic led;

  led_blink_arbiter_if #(.NUM_REQ(NR)) bus ();

  led_blink_arbiter #(
    .NUM_REQ     (NR),
    .HALF_PERIOD (HP),
    .GAP_HALVES  (GH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .led   (led)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int rr_model = 0;

  // Cycles from grant to the done cycle: both halves of every blink, the gap, plus the closing cycle.
  function automatic int burst_len(input int c);
    return (2 * c + GH) * HP + 1;
  endfunction

  // Expected {led, busy, gnt, done} t cycles after the grant edge.
  function automatic logic [9:0] expect_at(input int w, input int c, input int t);
    logic [3:0] oh;
    logic       l;
    oh = 4'(1 << w);
    if (t >= burst_len(c)) return {1'b0, 1'b0, 4'b0000, oh};
    l = (t < 2 * c * HP) && (((t / HP) % 2) == 0);
    return {l, 1'b1, oh, 4'b0000};
  endfunction

  function automatic int pick_model(input logic [3:0] r, input int rr);
    logic [3:0] sh;
    for (int i = 0; i < NR; i++) begin
      sh = r >> ((rr + i) % NR);
      if (sh[0]) return (rr + i) % NR;
    end
    return -1;
  endfunction

  function automatic logic [9:0] observed();
    return {led, bus.busy, bus.gnt, bus.done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge for t_from; leaves the bench at the negedge for t_to.
  task automatic observe(input string tag, input int w, input int c, input int t_from, input int t_to);
    for (int t = t_from; t <= t_to; t++) begin
      if (t != t_from) @(negedge clk);
      check($sformatf("%s_t%0d", tag, t), 32'(observed()), 32'(expect_at(w, c, t)));
    end
  endtask

  task automatic set_count(input int i, input int v);
    bus.req_count[i*4 +: 4] = 4'(v);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, k, c0, c2, c3;
    int cnt[NR];
    logic [3:0] r;

    bus.req       = '0;
    bus.req_count = '0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(observed()), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(observed()), 32'h0);

    // Single requester, three blinks.
    set_count(0, 3);
    bus.req = 4'b0001;
    @(negedge clk);
    observe("single3", 0, 3, 0, burst_len(3));
    bus.req  = '0;
    rr_model = 1;
    @(negedge clk);
    check("single3_idle", 32'(observed()), 32'h0);

    // Zero-count burst: gap only.
    set_count(2, 0);
    bus.req = 4'b0100;
    w = pick_model(bus.req, rr_model);
    @(negedge clk);
    observe("zero_cnt", w, 0, 0, burst_len(0));
    bus.req  = '0;
    rr_model = (w + 1) % NR;
    @(negedge clk);

    // Pointer now past requester 2: requester 3 beats requester 0.
    set_count(3, 0);
    bus.req = 4'b1001;
    w = pick_model(bus.req, rr_model);
    @(negedge clk);
    observe("rr_after_zero", w, 0, 0, burst_len(0));
    bus.req  = '0;
    rr_model = (w + 1) % NR;
    @(negedge clk);

    // All four held from reset: rotation 0,1,2,3,0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    rr_model      = 0;
    bus.req_count = 16'h1111;
    bus.req       = 4'b1111;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      w = pick_model(bus.req, rr_model);
      observe($sformatf("rotate_g%0d", g), w, 1, 0, burst_len(1));
      rr_model = (w + 1) % NR;
      if (g < 4) @(negedge clk);
    end
    bus.req = '0;
    @(negedge clk);
    check("rotate_idle", 32'(observed()), 32'h0);

    // Abort during the second ON phase, then requester 2 takes over.
    c2 = int'($urandom_range(0, 3));
    bus.req_count = '0;
    set_count(1, 5);
    set_count(2, c2);
    bus.req = 4'b0110;
    w = pick_model(bus.req, rr_model);
    @(negedge clk);
    k = int'($urandom_range(2 * HP, 3 * HP - 1));
    observe("abort", w, 5, 0, k);
    bus.req = 4'b0100;
    @(negedge clk);
    check("abort_release", 32'(observed()), 32'h0);
    rr_model = (w + 1) % NR;
    w = pick_model(bus.req, rr_model);
    @(negedge clk);
    observe("after_abort", w, c2, 0, burst_len(c2));
    bus.req  = '0;
    rr_model = (w + 1) % NR;
    @(negedge clk);

    // One-cycle reset mid-burst; afterwards the pointer is back at 0.
    c3 = int'($urandom_range(1, 5));
    set_count(3, c3);
    bus.req = 4'b1000;
    w = pick_model(bus.req, rr_model);
    @(negedge clk);
    k = int'($urandom_range(0, burst_len(c3) - 2));
    observe("pre_reset", w, c3, 0, k);
    rst_n   = 1'b0;
    bus.req = 4'b1001;
    c0 = int'($urandom_range(0, 3));
    set_count(0, c0);
    @(negedge clk);
    check("mid_reset", 32'(observed()), 32'h0);
    rst_n    = 1'b1;
    rr_model = 0;
    w = pick_model(bus.req, rr_model);
    @(negedge clk);
    observe("post_reset", w, c0, 0, burst_len(c0));
    bus.req  = '0;
    rr_model = (w + 1) % NR;
    @(negedge clk);

    // Count changed right after grant must not alter the burst.
    bus.req_count = '0;
    set_count(0, 7);
    bus.req = 4'b0001;
    w = pick_model(bus.req, rr_model);
    @(negedge clk);
    observe("late_count", w, 7, 0, 0);
    set_count(0, 2);
    @(negedge clk);
    observe("late_count", w, 7, 1, burst_len(7));
    bus.req  = '0;
    rr_model = (w + 1) % NR;

    // Randomized request patterns and counts.
    for (int it = 0; it < 8; it++) begin
      @(negedge clk);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
      check($sformatf("rand%0d_idle", it), 32'(observed()), 32'h0);
      r = 4'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++) begin
        cnt[i] = int'($urandom_range(0, 3));
        set_count(i, cnt[i]);
      end
      bus.req = r;
      w = pick_model(r, rr_model);
      @(negedge clk);
      observe($sformatf("rand%0d", it), w, cnt[w], 0, burst_len(cnt[w]));
      bus.req  = '0;
      rr_model = (w + 1) % NR;
    end

    @(negedge clk);
    check("final_idle", 32'(observed()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
